// File: rtl/regfile_bypass.sv
// Integer register file: two combinational read ports, two write-back ports
// (w1 has priority), optional same-cycle write-to-read forwarding and a
// per-register busy scoreboard set at issue and cleared at write-back.
// Register 0 always reads zero and is never busy.
module regfile_bypass #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned BYPASS = 32'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_addr,
    input  logic [XLEN-1:0] w0_data,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    input  logic [XLEN-1:0] w1_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush
);

    localparam bit BYP_EN = (BYPASS != 32'd0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Writes/issues aimed at register 0 are dropped entirely.
    logic w0_hit_s;
    logic w1_hit_s;
    logic iss_hit_s;

    assign w0_hit_s  = w0_en  && (w0_addr != '0);
    assign w1_hit_s  = w1_en  && (w1_addr != '0);
    assign iss_hit_s = iss_en && (iss_rd  != '0);

    // Read-port resolution: {busy, data}. Forwarded writes also hide the
    // busy bit, since the producer is retiring in this very cycle.
    function automatic logic [XLEN:0] read_port(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] arr_val,
        input logic            arr_busy,
        input logic            w0_hit,
        input logic [AW-1:0]   w0_a,
        input logic [XLEN-1:0] w0_d,
        input logic            w1_hit,
        input logic [AW-1:0]   w1_a,
        input logic [XLEN-1:0] w1_d
    );
        logic [XLEN-1:0] data;
        logic            busy;
        logic            fwd0;
        logic            fwd1;
        fwd1 = BYP_EN && w1_hit && (w1_a == a);
        fwd0 = BYP_EN && w0_hit && (w0_a == a);
        if (a == '0) begin
            data = '0;
        end else if (fwd1) begin
            data = w1_d;
        end else if (fwd0) begin
            data = w0_d;
        end else begin
            data = arr_val;
        end
        if (a == '0) begin
            busy = 1'b0;
        end else begin
            busy = arr_busy && !(fwd0 || fwd1);
        end
        return {busy, data};
    endfunction

    assign {rs1_busy, rs1_data} = read_port(rs1_addr, mem_q[rs1_addr], busy_q[rs1_addr],
                                            w0_hit_s, w0_addr, w0_data,
                                            w1_hit_s, w1_addr, w1_data);
    assign {rs2_busy, rs2_data} = read_port(rs2_addr, mem_q[rs2_addr], busy_q[rs2_addr],
                                            w0_hit_s, w0_addr, w0_data,
                                            w1_hit_s, w1_addr, w1_data);

    // Next array contents: w1 overrides w0 when both target the same entry.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            if (w1_hit_s && (w1_addr == AW'(i))) begin
                mem_d[i] = w1_data;
            end else if (w0_hit_s && (w0_addr == AW'(i))) begin
                mem_d[i] = w0_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Next busy bits: flush clears all; otherwise a new issue beats a retiring write.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (iss_hit_s && (iss_rd == AW'(i))) begin
                    busy_d[i] = 1'b1;
                end else if ((w0_hit_s && (w0_addr == AW'(i))) ||
                             (w1_hit_s && (w1_addr == AW'(i)))) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_q[i];
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    // Array storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Busy scoreboard storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised integer register file with two read ports, two write-back ports, same-cycle write-to-read bypass, and a per-register busy scoreboard. It is the next-generation regfile for the pipelined core: the decode stage reads operands and marks destinations busy at issue; the execute and memory write-back paths retire results and clear busy bits. Register 0 is hardwired to zero and never busy.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREG), address width (derived; do not override)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return array contents only

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rs1_addr  input  AW  read port 1 address
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs1_busy  output  1  register at rs1_addr has an outstanding producer
- rs2_addr  input  AW  read port 2 address
- rs2_data  output  XLEN  read port 2 data (combinational)
- rs2_busy  output  1  register at rs2_addr has an outstanding producer
- w0_en  input  1  write port 0 enable (execute write-back)
- w0_addr  input  AW  write port 0 address
- w0_data  input  XLEN  write port 0 data
- w1_en  input  1  write port 1 enable (memory write-back; priority port)
- w1_addr  input  AW  write port 1 address
- w1_data  input  XLEN  write port 1 data
- iss_en  input  1  issue: mark iss_rd busy
- iss_rd  input  AW  destination register being issued
- flush  input  1  clear every busy bit (pipeline flush)

## Operation
- Storage: NREG×XLEN array plus NREG busy bits; entry 0 is not stored (reads 0, busy 0).
- Write: on rising edge, w0_en with w0_addr≠0 writes w0_data; w1_en with w1_addr≠0 writes w1_data. Both ports to the same nonzero address: w1 wins, w0 discarded.
- Read (per port, addr a): a=0 → data 0. Else if BYPASS=1 and w1_en & w1_addr=a → w1_data; else if BYPASS=1 and w0_en & w0_addr=a → w0_data; else array[a].
- Busy set: iss_en & iss_rd≠0 sets busy[iss_rd] at the rising edge.
- Busy clear: any enabled write port to address a clears busy[a] at the rising edge.
- Simultaneous set and clear on same address: set wins (new producer supersedes retiring one).
- flush: all busy bits cleared at rising edge; flush overrides a same-cycle issue (busy[iss_rd] ends 0). Writes in the flush cycle still commit to the array.
- Busy output (per port, addr a): a=0 → 0. Else busy[a] AND NOT (BYPASS=1 AND an enabled write port targets a this cycle). With BYPASS=0, busy output is the stored bit only.
- Issue in the current cycle does not affect rsN_busy until the next cycle.
- Out-of-range addresses cannot occur (NREG power of two).

## Timing
- Reset (rst_n low, asynchronous): all array entries 0, all busy bits 0; therefore rs1_data=rs2_data=0, rs1_busy=rs2_busy=0 immediately, independent of clk. Deassertion is synchronised externally; first write accepted on the first rising edge with rst_n high.
- Reset asserted mid-cycle with writes/issue pending: pending operations are lost; state is all-zero.
- Read latency: 0 cycles (combinational from addresses and write ports).
- Write latency: 1 edge; array value visible without bypass from the cycle after the edge.
- Busy latency: set visible the cycle after issue; clear visible combinationally in the write cycle (BYPASS=1) or the cycle after (BYPASS=0).
- No handshake; all enables are single-cycle qualifiers sampled on the rising edge.

## Test plan
- Reset: write x5=0xDEADBEEF, assert rst_n low between edges → rs1_addr=5 reads 0x00000000 immediately, rs1_busy=0.
- x0 protection: w0 writes 0x12345678 to addr 0, iss_en iss_rd=0 → rs1_addr=0 reads 0, rs1_busy=0 on all later cycles.
- Dual-write conflict + bypass: same cycle w0 (addr 7, 0x11111111) and w1 (addr 7, 0x22222222), rs1_addr=7 → rs1_data=0x22222222 that cycle; next cycle with no writes rs1_data=0x22222222.
- Scoreboard: issue rd=3 at cycle N → rs2_busy(3)=0 in N, 1 in N+1…; w0 writes addr 3 value 0xA5 at cycle M → rs2_busy=0 and rs2_data=0xA5 in cycle M, busy stays 0 after.
- Set/clear collision: busy[9]=1, same cycle iss_en rd=9 and w1 writes addr 9 → next cycle rs1_busy(9)=1, array[9] updated.
- Flush: busy[4], busy[6]=1, flush with iss_en rd=8 same cycle → next cycle busy for 4, 6, 8 all 0; BYPASS=0 variant: write to busy reg shows old data and busy=1 in write cycle, new data and busy=0 next cycle.
